memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Memory stage of the RISC-V core, between execute and register writeback.
- Issues loads and stores to the data-memory bus using a req/ack handshake.
- Aligns store data and byte enables to the bus word, and right-justifies load data.
- Registers the stage results for writeback. Stalls upstream while a bus access is outstanding.

Parameters:
TIMEOUT_CYCLES, 0, max cycles to wait for dmem_ack before abandoning the access; 0 disables the timeout. Legal range 0..65535.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_noop  in  1  bubble from execute
in_opcode  in  7  instruction opcode
in_funct3  in  3  funct3
in_rd  in  5  destination register
in_imm  in  32  immediate
in_res  in  32  ALU result; the byte address for loads and stores
in_rs2  in  32  store source data
stall  out  1  upstream must hold all in_* stable while high
dmem_req  out  1  bus request
dmem_we  out  1  1 = store
dmem_addr  out  32  word address, {in_res[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  store data
dmem_ack  in  1  access complete; dmem_rdata is valid in the same cycle
dmem_rdata  in  32  load data
out_noop, out_opcode, out_funct3, out_rd, out_imm, out_res  out  1/7/3/5/32/32  registered copies to writeback
out_mem_rd  out  32  right-justified load data; upper bits zero
out_misaligned  out  1  one-cycle pulse on a misaligned access
out_bus_err  out  1  one-cycle pulse on an access timeout

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset values: FSM in IDLE, out_noop=1, all other outputs 0, timeout counter 0.
- While rst=1, dmem_req=0 and stall=0.
- Mem op = in_noop=0 and either:
  - load: opcode 0000011 with funct3 in {0,1,2,4,5}, or
  - store: opcode 0100011 with funct3 in {0,1,2}.
- Misaligned:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0.
  - Result: no bus request, out_noop=1, out_misaligned=1 for one cycle, latency 1.
- Load/store opcode with any other funct3: no bus request, out_noop=1, no error pulse.
- Non-mem ops and noops:
  - out_* <= in_* on the next edge; out_mem_rd <= 0; latency 1.
- FSM states: IDLE, WAIT.
  - IDLE, aligned mem op: dmem_req=1, with addr/we/be/wdata decoded combinationally from in_*.
  - IDLE, dmem_ack=1 in the same cycle: outputs register at the edge, stay in IDLE; zero-wait access, latency 1.
  - IDLE, dmem_ack=0: stall=1, latch the request fields, go to WAIT.
  - WAIT: dmem_req=1 with latched fields held stable. On dmem_ack: register outputs, return to IDLE. stall = !dmem_ack, so stall drops in the ack cycle.
  - Each stalled cycle presents out_noop=1 to writeback (bubble).
- Stall equation: stall = (IDLE & aligned mem op & !dmem_ack) | (WAIT & !dmem_ack).
- Store alignment (off = addr[1:0]):
  - SB: be=0001<<off, wdata = rs2[7:0] replicated x4.
  - SH: be=0011<<off, wdata = rs2[15:0] replicated x2.
  - SW: be=1111, wdata = rs2.
- Loads: dmem_be=1111. out_mem_rd = dmem_rdata >> (8*off), masked to 8 bits (funct3 0/4), 16 bits (1/5) or 32 bits (2). Sign/zero extension is done in writeback.
- Stores: pass through to writeback unchanged; out_mem_rd=0.
- Timeout (TIMEOUT_CYCLES>0): the counter increments each WAIT cycle without ack. When it reaches TIMEOUT_CYCLES:
  - go to IDLE, stall=0;
  - out_noop=1, out_bus_err=1 for one cycle.
- dmem_ack while dmem_req=0 is ignored.
- Reset during WAIT: dmem_req drops in the reset cycle and the access is abandoned; the bus must tolerate this.

Decomposition:
- riscv_pkg holds:
  - opcode constants OP_LOAD, OP_STORE, OP_ALU, OP_ALUI, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI;
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the FSM state enum mem_state_t.
- One combinational sub-module, lsu_align, produces be/wdata from funct3/offset/rs2 and the extracted load data from funct3/offset/rdata.

Test Plan:
- ALU op: in_res=0x1234 -> next cycle out_res=0x1234, out_mem_rd=0, dmem_req never asserted.
- SB with addr=0x103, rs2=0xAABBCCDD, ack same cycle -> dmem_addr=0x100, be=1000, wdata=0xDDDDDDDD, stall=0.
- LBU with addr=0x202, rdata=0x11223344, ack after 3 cycles -> stall high 3 cycles, out_noop=1 for those cycles, then out_mem_rd=0x22.
- LH with addr=0x301 -> no dmem_req, out_misaligned pulses, out_noop=1.
- TIMEOUT_CYCLES=4, LW never acked -> stall drops after 4 WAIT cycles, out_bus_err pulses, FSM back in IDLE.
- rst asserted mid-WAIT -> next cycle dmem_req=0, out_noop=1; a following LW with ack completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings and memory-stage FSM state used by the memory_access stage.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    // Halfwords need even addresses, words need 4-byte aligned addresses.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_H, F3_HU: is_misaligned = off[0];
            F3_W:        is_misaligned = (off != 2'b00);
            default:     is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/data placed on the bus word, load data right-justified.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = i_rdata >> {i_off, 3'b000};
        o_be      = 4'b1111;
        o_wdata   = i_rs2;
        o_ld_data = w_shifted;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be      = 4'b0001 << i_off;
                o_wdata   = {4{i_rs2[7:0]}};
                o_ld_data = {24'h000000, w_shifted[7:0]};
            end
            F3_H, F3_HU: begin
                o_be      = 4'b0011 << i_off;
                o_wdata   = {2{i_rs2[15:0]}};
                o_ld_data = {16'h0000, w_shifted[15:0]};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory stage: issues loads/stores on a req/ack bus, stalls upstream while an access is
// outstanding, and registers results for writeback.
module memory_access
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_noop,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_res,
    input  logic [31:0] in_rs2,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        out_noop,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic [31:0] out_res,
    output logic [31:0] out_mem_rd,
    output logic        out_misaligned,
    output logic        out_bus_err,
    output logic        dbg_state
);

    localparam logic [15:0] L_TIMEOUT = TIMEOUT_CYCLES[15:0];

    mem_state_t  r_state, w_next;
    logic [15:0] r_cnt;
    logic [6:0]  r_l_opcode;
    logic [2:0]  r_l_funct3;
    logic [4:0]  r_l_rd;
    logic [31:0] r_l_imm, r_l_res, r_l_rs2;

    logic        w_in_wait, w_noop, w_ldst_op, w_is_load, w_is_store, w_misal, w_go, w_timeout;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic [31:0] w_imm, w_res, w_rs2;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata, w_ld_data;

    // In WAIT the latched copy drives decode, so the bus fields stay stable until ack.
    always_comb begin
        w_in_wait  = (r_state == ST_WAIT);
        w_noop     = w_in_wait ? 1'b0       : in_noop;
        w_opcode   = w_in_wait ? r_l_opcode : in_opcode;
        w_funct3   = w_in_wait ? r_l_funct3 : in_funct3;
        w_rd       = w_in_wait ? r_l_rd     : in_rd;
        w_imm      = w_in_wait ? r_l_imm    : in_imm;
        w_res      = w_in_wait ? r_l_res    : in_res;
        w_rs2      = w_in_wait ? r_l_rs2    : in_rs2;
        w_ldst_op  = !w_noop && (w_opcode == OP_LOAD || w_opcode == OP_STORE);
        w_is_load  = !w_noop && (w_opcode == OP_LOAD) &&
                     (w_funct3 == F3_B || w_funct3 == F3_H || w_funct3 == F3_W ||
                      w_funct3 == F3_BU || w_funct3 == F3_HU);
        w_is_store = !w_noop && (w_opcode == OP_STORE) &&
                     (w_funct3 == F3_B || w_funct3 == F3_H || w_funct3 == F3_W);
        w_misal    = (w_is_load || w_is_store) && is_misaligned(w_funct3, w_res[1:0]);
        w_go       = (w_is_load || w_is_store) && !w_misal;
        w_timeout  = (L_TIMEOUT != 16'd0) && w_in_wait && (r_cnt == L_TIMEOUT);
    end

    lsu_align u_align (
        .i_funct3  (w_funct3),
        .i_off     (w_res[1:0]),
        .i_rs2     (w_rs2),
        .i_rdata   (dmem_rdata),
        .o_be      (w_st_be),
        .o_wdata   (w_st_wdata),
        .o_ld_data (w_ld_data)
    );

    // Handshake: dmem_req holds with stable fields until the cycle dmem_ack is seen high;
    // that cycle completes the access. Ack with req low is ignored. The timeout cycle drops
    // req, so an ack arriving then is ignored too.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_go && !dmem_ack) w_next = ST_WAIT;
            ST_WAIT: if (dmem_ack || w_timeout) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        dmem_req   = !rst && w_go && !w_timeout;
        stall      = !rst && w_go && !dmem_ack && !w_timeout;
        dmem_we    = w_is_store;
        dmem_addr  = {w_res[31:2], 2'b00};
        dmem_be    = w_is_store ? w_st_be : 4'b1111;
        dmem_wdata = w_st_wdata;
        dbg_state  = r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 16'd0;
            r_l_opcode     <= 7'd0;
            r_l_funct3     <= 3'd0;
            r_l_rd         <= 5'd0;
            r_l_imm        <= 32'd0;
            r_l_res        <= 32'd0;
            r_l_rs2        <= 32'd0;
            out_noop       <= 1'b1;
            out_opcode     <= 7'd0;
            out_funct3     <= 3'd0;
            out_rd         <= 5'd0;
            out_imm        <= 32'd0;
            out_res        <= 32'd0;
            out_mem_rd     <= 32'd0;
            out_misaligned <= 1'b0;
            out_bus_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_in_wait && w_next == ST_WAIT) ? r_cnt + 16'd1 : 16'd0;
            if (!w_in_wait && w_next == ST_WAIT) begin
                r_l_opcode <= in_opcode;
                r_l_funct3 <= in_funct3;
                r_l_rd     <= in_rd;
                r_l_imm    <= in_imm;
                r_l_res    <= in_res;
                r_l_rs2    <= in_rs2;
            end
            out_opcode     <= w_opcode;
            out_funct3     <= w_funct3;
            out_rd         <= w_rd;
            out_imm        <= w_imm;
            out_res        <= w_res;
            out_noop       <= 1'b1;
            out_mem_rd     <= 32'd0;
            out_misaligned <= 1'b0;
            out_bus_err    <= 1'b0;
            if (w_timeout) begin
                out_bus_err <= 1'b1;
            end else if (w_go) begin
                if (dmem_ack) begin
                    out_noop <= 1'b0;
                    if (w_is_load) out_mem_rd <= w_ld_data;
                end
            end else if (w_misal) begin
                out_misaligned <= 1'b1;
            end else if (!w_ldst_op) begin
                out_noop <= in_noop;
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed scenarios plus randomized transactions against a
// byte-level reference model.
module tb_memory_access;
  import riscv_pkg::*;

  localparam int TMO = 4;

  logic        clk, rst;
  logic        in_noop;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [31:0] in_imm, in_res, in_rs2;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        out_noop;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd;
  logic [31:0] out_imm, out_res, out_mem_rd;
  logic        out_misaligned, out_bus_err, dbg_state;

  int checks = 0;
  int errors = 0;

  memory_access #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_noop(in_noop), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
    .in_imm(in_imm), .in_res(in_res), .in_rs2(in_rs2),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_noop(out_noop), .out_opcode(out_opcode), .out_funct3(out_funct3), .out_rd(out_rd),
    .out_imm(out_imm), .out_res(out_res), .out_mem_rd(out_mem_rd),
    .out_misaligned(out_misaligned), .out_bus_err(out_bus_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic set_op(input logic noop, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] res,
                        input logic [31:0] rs2);
    in_noop = noop; in_opcode = op; in_funct3 = f3; in_rd = rd;
    in_imm = imm; in_res = res; in_rs2 = rs2;
  endtask

  task automatic set_idle();
    set_op(1'b1, OP_ALU, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    set_op(1'b0, OP_LOAD, F3_W, 5'd3, 32'd0, 32'h40, 32'd0);
    dmem_ack = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b want 0", dmem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", stall); end
    @(posedge clk); #1;
    checks++; if (out_noop !== 1'b1) begin errors++; $display("FAIL rst_noop got %0b want 1", out_noop); end
    checks++; if (out_res !== 32'd0) begin errors++; $display("FAIL rst_res got %h want 0", out_res); end
    checks++; if (out_mem_rd !== 32'd0) begin errors++; $display("FAIL rst_memrd got %h want 0", out_mem_rd); end
    checks++; if (out_misaligned !== 1'b0 || out_bus_err !== 1'b0) begin errors++;
      $display("FAIL rst_pulses got %0b%0b want 00", out_misaligned, out_bus_err); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL rst_state got %0b want 0", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    set_idle();
  endtask

  task automatic test_alu();
    @(negedge clk);
    set_op(1'b0, OP_ALU, 3'd0, 5'd5, 32'h7, 32'h1234, 32'h99);
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL alu_req got %0b want 0", dmem_req); end
    @(posedge clk); #1;
    checks++; if (out_res !== 32'h1234) begin errors++; $display("FAIL alu_res got %h want 1234", out_res); end
    checks++; if (out_mem_rd !== 32'd0) begin errors++; $display("FAIL alu_memrd got %h want 0", out_mem_rd); end
    checks++; if (out_noop !== 1'b0 || out_rd !== 5'd5 || out_opcode !== OP_ALU) begin errors++;
      $display("FAIL alu_fields got noop=%0b rd=%0d op=%h want 0/5/%h", out_noop, out_rd, out_opcode, OP_ALU); end
  endtask

  task automatic test_sb();
    @(negedge clk);
    set_op(1'b0, OP_STORE, F3_B, 5'd0, 32'd0, 32'h103, 32'hAABBCCDD);
    dmem_ack = 1'b1;
    #1;
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++;
      $display("FAIL sb_req got req=%0b we=%0b want 1/1", dmem_req, dmem_we); end
    checks++; if (dmem_addr !== 32'h100) begin errors++; $display("FAIL sb_addr got %h want 100", dmem_addr); end
    checks++; if (dmem_be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b want 1000", dmem_be); end
    checks++; if (dmem_wdata !== 32'hDDDDDDDD) begin errors++; $display("FAIL sb_wdata got %h want DDDDDDDD", dmem_wdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_stall got %0b want 0", stall); end
    @(posedge clk); #1;
    checks++; if (out_noop !== 1'b0 || out_mem_rd !== 32'd0) begin errors++;
      $display("FAIL sb_out got noop=%0b memrd=%h want 0/0", out_noop, out_mem_rd); end
    dmem_ack = 1'b0;
  endtask

  task automatic test_lbu_wait();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) set_op(1'b0, OP_LOAD, F3_BU, 5'd9, 32'd0, 32'h202, 32'd0);
      dmem_ack = (k == 3);
      dmem_rdata = (k == 3) ? 32'h11223344 : $urandom;
      #1;
      checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h200 || dmem_be !== 4'hF) begin errors++;
        $display("FAIL lbu_bus%0d got req=%0b addr=%h be=%b want 1/200/1111", k, dmem_req, dmem_addr, dmem_be); end
      checks++; if (stall !== (k != 3)) begin errors++; $display("FAIL lbu_stall%0d got %0b want %0b", k, stall, k != 3); end
      @(posedge clk); #1;
      if (k != 3) begin
        checks++; if (out_noop !== 1'b1) begin errors++; $display("FAIL lbu_bubble%0d got %0b want 1", k, out_noop); end
      end
    end
    checks++; if (out_noop !== 1'b0 || out_mem_rd !== 32'h22) begin errors++;
      $display("FAIL lbu_done got noop=%0b memrd=%h want 0/22", out_noop, out_mem_rd); end
    dmem_ack = 1'b0;
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    set_op(1'b0, OP_LOAD, F3_H, 5'd4, 32'd0, 32'h301, 32'd0);
    #1;
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin errors++;
      $display("FAIL mis_req got req=%0b stall=%0b want 0/0", dmem_req, stall); end
    @(posedge clk); #1;
    checks++; if (out_misaligned !== 1'b1 || out_noop !== 1'b1) begin errors++;
      $display("FAIL mis_pulse got mis=%0b noop=%0b want 1/1", out_misaligned, out_noop); end
    @(negedge clk);
    set_op(1'b0, OP_STORE, 3'd3, 5'd0, 32'd0, 32'h400, 32'd1);
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL badf3_req got %0b want 0", dmem_req); end
    @(posedge clk); #1;
    checks++; if (out_misaligned !== 1'b0 || out_noop !== 1'b1 || out_bus_err !== 1'b0) begin errors++;
      $display("FAIL badf3_out got mis=%0b noop=%0b err=%0b want 0/1/0", out_misaligned, out_noop, out_bus_err); end
  endtask

  task automatic test_timeout();
    for (int k = 0; k <= TMO + 1; k++) begin
      @(negedge clk);
      if (k == 0) set_op(1'b0, OP_LOAD, F3_W, 5'd1, 32'd0, 32'h400, 32'd0);
      if (k == TMO + 1) set_op(1'b1, OP_ALU, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
      dmem_ack = 1'b0;
      #1;
      if (k <= TMO) begin
        checks++; if (stall !== 1'b1 || dmem_req !== 1'b1) begin errors++;
          $display("FAIL tmo_wait%0d got stall=%0b req=%0b want 1/1", k, stall, dmem_req); end
      end else begin
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL tmo_stall got %0b want 0", stall); end
      end
      @(posedge clk); #1;
      if (k <= TMO) begin
        checks++; if (out_bus_err !== 1'b0 || out_noop !== 1'b1) begin errors++;
          $display("FAIL tmo_early%0d got err=%0b noop=%0b want 0/1", k, out_bus_err, out_noop); end
      end else begin
        checks++; if (out_bus_err !== 1'b1 || out_noop !== 1'b1 || dbg_state !== 1'b0) begin errors++;
          $display("FAIL tmo_err got err=%0b noop=%0b state=%0b want 1/1/0", out_bus_err, out_noop, dbg_state); end
      end
    end
    @(posedge clk); #1;
    checks++; if (out_bus_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse got %0b want 0", out_bus_err); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd_val;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k == 0) set_op(1'b0, OP_LOAD, F3_W, 5'd2, 32'd0, 32'h500, 32'd0);
      dmem_ack = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin errors++;
      $display("FAIL rstw_req got req=%0b stall=%0b want 0/0", dmem_req, stall); end
    @(posedge clk); #1;
    checks++; if (out_noop !== 1'b1 || dbg_state !== 1'b0) begin errors++;
      $display("FAIL rstw_out got noop=%0b state=%0b want 1/0", out_noop, dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    rd_val = $urandom;
    set_op(1'b0, OP_LOAD, F3_W, 5'd3, 32'd0, 32'h504, 32'd0);
    dmem_ack = 1'b1;
    dmem_rdata = rd_val;
    #1;
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h504 || stall !== 1'b0) begin errors++;
      $display("FAIL rstw_lw got req=%0b addr=%h stall=%0b want 1/504/0", dmem_req, dmem_addr, stall); end
    @(posedge clk); #1;
    checks++; if (out_noop !== 1'b0 || out_mem_rd !== rd_val) begin errors++;
      $display("FAIL rstw_done got noop=%0b memrd=%h want 0/%h", out_noop, out_mem_rd, rd_val); end
    dmem_ack = 1'b0;
  endtask

  // Randomized back-to-back transactions against a byte-level model.
  task automatic test_random();
    logic [6:0]  others[6];
    logic        noop, is_ld, is_st, misal, go, exp_noop;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] res, rs2, imm, rdata, exp_wd, exp_mrd;
    logic [3:0]  exp_be;
    logic [63:0] mask;
    int          cat, d, size, off;
    others = '{OP_ALU, OP_ALUI, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI};
    for (int t = 0; t < 120; t++) begin
      cat  = $urandom_range(0, 5);
      d    = $urandom_range(0, 3);
      noop = (cat == 1);
      op   = (cat == 0) ? others[$urandom_range(0, 5)] : ((cat <= 3) ? OP_LOAD : OP_STORE);
      f3   = 3'($urandom_range(0, 7));
      rd   = 5'($urandom_range(0, 31));
      res  = $urandom; rs2 = $urandom; imm = $urandom; rdata = 32'd0;
      is_ld = !noop && op == OP_LOAD && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      is_st = !noop && op == OP_STORE && f3 <= 2;
      size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
      off   = int'(res % 4);
      misal = (is_ld || is_st) && (res % size != 0);
      go    = (is_ld || is_st) && !misal;
      exp_noop = noop ? 1'b1 : ((op == OP_LOAD || op == OP_STORE) ? !go : 1'b0);
      exp_be = is_st ? 4'(((1 << size) - 1) << off) : 4'hF;
      exp_wd = (size == 1) ? rs2[7:0] * 32'h01010101 : ((size == 2) ? rs2[15:0] * 32'h00010001 : rs2);
      if (!go) d = 0;
      for (int k = 0; k <= d; k++) begin
        @(negedge clk);
        if (k == 0) set_op(noop, op, f3, rd, imm, res, rs2);
        if (go) dmem_ack = (k == d);
        else dmem_ack = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        if (k == d) rdata = dmem_rdata;
        #1;
        checks++; if (dmem_req !== go) begin errors++; $display("FAIL rnd%0d_req got %0b want %0b", t, dmem_req, go); end
        checks++; if (stall !== (go && k != d)) begin errors++;
          $display("FAIL rnd%0d_stall got %0b want %0b", t, stall, go && k != d); end
        if (go) begin
          checks++; if (dmem_addr !== {res[31:2], 2'b00} || dmem_be !== exp_be || dmem_we !== is_st) begin errors++;
            $display("FAIL rnd%0d_bus got addr=%h be=%b we=%0b want %h/%b/%0b", t, dmem_addr, dmem_be, dmem_we,
                     {res[31:2], 2'b00}, exp_be, is_st); end
          if (is_st) begin
            checks++; if (dmem_wdata !== exp_wd) begin errors++;
              $display("FAIL rnd%0d_wdata got %h want %h", t, dmem_wdata, exp_wd); end
          end
        end
        @(posedge clk); #1;
        if (k != d) begin
          checks++; if (out_noop !== 1'b1) begin errors++; $display("FAIL rnd%0d_bubble got %0b want 1", t, out_noop); end
        end
      end
      mask = (64'd1 << (8 * size)) - 64'd1;
      exp_mrd = (is_ld && go) ? 32'((64'(rdata) >> (8 * off)) & mask) : 32'd0;
      checks++; if (out_noop !== exp_noop) begin errors++; $display("FAIL rnd%0d_noop got %0b want %0b", t, out_noop, exp_noop); end
      checks++; if (out_res !== res || out_rd !== rd || out_imm !== imm) begin errors++;
        $display("FAIL rnd%0d_fields got res=%h rd=%0d imm=%h want %h/%0d/%h", t, out_res, out_rd, out_imm, res, rd, imm); end
      checks++; if (out_mem_rd !== exp_mrd) begin errors++; $display("FAIL rnd%0d_memrd got %h want %h", t, out_mem_rd, exp_mrd); end
      checks++; if (out_misaligned !== misal || out_bus_err !== 1'b0) begin errors++;
        $display("FAIL rnd%0d_pulse got mis=%0b err=%0b want %0b/0", t, out_misaligned, out_bus_err, misal); end
    end
    @(negedge clk);
    set_idle();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_alu();
    test_sb();
    test_lbu_wait();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
